wb_arbiter_4x1: RTL and testbench

WB_ARBITER_4X1 -- requirements
Module: wb_arbiter_4x1

---
 rtl/wb_sys_pkg.sv | 15 +
 rtl/wb_if.sv | 27 ++
 rtl/wb_rr_arb4.sv | 28 ++
 rtl/wb_arbiter_4x1.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter_4x1.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_sys_pkg.sv
// Shared types for the Wishbone 4:1 arbiter: FSM state encoding and master index.
package wb_sys_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TERR = 2'd2
  } arb_state_t;

  typedef logic [1:0] master_idx_t;

  localparam int          NUM_MASTERS = 4;
  localparam master_idx_t RESET_LAST  = 2'd3;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 classic/registered-feedback bus bundle with master and slave views.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    cyc;
  logic                    stb;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_rr_arb4.sv
// Combinational 4-way round-robin pick: first requester after 'last', wrapping.
module wb_rr_arb4
  import wb_sys_pkg::*;
(
  input  logic [3:0]  req,
  input  master_idx_t last,
  output master_idx_t idx,
  output logic        valid
);

  master_idx_t cand;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    idx   = last;
    valid = 1'b0;
    cand  = last;
    // Walk from farthest to nearest so the nearest requester after 'last' overwrites.
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = master_idx_t'(last + master_idx_t'(k));
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_4x1.sv
// Four Wishbone masters onto one slave: round-robin grant, burst hold, STB timeout.
module wb_arbiter_4x1
  import wb_sys_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.slave  m2,
  wb_if.slave  m3,
  wb_if.master s0
);

  localparam int SEL_WIDTH = WB_DATA_WIDTH / 8;
  localparam int CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] THRESH  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [WB_ADDR_WIDTH-1:0] adr_a   [NUM_MASTERS];
  logic [WB_DATA_WIDTH-1:0] dat_w_a [NUM_MASTERS];
  logic [SEL_WIDTH-1:0]     sel_a   [NUM_MASTERS];
  logic [2:0]               cti_a   [NUM_MASTERS];
  logic [1:0]               bte_a   [NUM_MASTERS];
  logic [3:0]               we_a, stb_a, req;

  assign adr_a   = '{m0.adr, m1.adr, m2.adr, m3.adr};
  assign dat_w_a = '{m0.dat_w, m1.dat_w, m2.dat_w, m3.dat_w};
  assign sel_a   = '{m0.sel, m1.sel, m2.sel, m3.sel};
  assign cti_a   = '{m0.cti, m1.cti, m2.cti, m3.cti};
  assign bte_a   = '{m0.bte, m1.bte, m2.bte, m3.bte};
  assign we_a    = {m3.we, m2.we, m1.we, m0.we};
  assign stb_a   = {m3.stb, m2.stb, m1.stb, m0.stb};
  assign req     = {m3.cyc, m2.cyc, m1.cyc, m0.cyc};

  arb_state_t  state_q, state_d;
  master_idx_t grant_q, grant_d;
  master_idx_t last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_first_q, err_first_d;

  master_idx_t rr_idx;
  logic        rr_valid;
  logic        busy, unanswered, timeout_hit;
  logic [3:0]  ack_v, err_v;

  wb_rr_arb4 u_rr (
    .req   (req),
    .last  (last_q),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  assign busy        = (state_q == BUSY);
  assign unanswered  = busy && stb_a[grant_q] && !s0.ack && !s0.err;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && unanswered && (cnt_q == THRESH);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = '0;
    err_first_d = 1'b0;

    if (unanswered) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Dropped CYC ends the tenancy even if the timeout would fire this cycle.
        if (!req[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d     = TERR;
          err_first_d = 1'b1;
        end
      end
      TERR: begin
        if (!req[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= RESET_LAST;
      cnt_q       <= '0;
      err_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      err_first_q <= err_first_d;
    end
  end

  assign s0.adr   = adr_a[grant_q];
  assign s0.dat_w = dat_w_a[grant_q];
  assign s0.sel   = sel_a[grant_q];
  assign s0.cti   = cti_a[grant_q];
  assign s0.bte   = bte_a[grant_q];
  assign s0.we    = we_a[grant_q];
  assign s0.cyc   = busy && req[grant_q];
  assign s0.stb   = busy && stb_a[grant_q];

  always_comb begin
    ack_v = '0;
    err_v = '0;
    ack_v[grant_q] = busy && s0.ack;
    err_v[grant_q] = (busy && s0.err) || ((state_q == TERR) && err_first_q);
  end

  assign m0.ack = ack_v[0];
  assign m1.ack = ack_v[1];
  assign m2.ack = ack_v[2];
  assign m3.ack = ack_v[3];
  assign m0.err = err_v[0];
  assign m1.err = err_v[1];
  assign m2.err = err_v[2];
  assign m3.err = err_v[3];
  assign m0.dat_r = s0.dat_r;
  assign m1.dat_r = s0.dat_r;
  assign m2.dat_r = s0.dat_r;
  assign m3.dat_r = s0.dat_r;

endmodule

// File: tb/tb_wb_arbiter_4x1.sv
// Directed bench for wb_arbiter_4x1: grant order, burst hold, timeout and reset abort.
module tb_wb_arbiter_4x1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m2_bus ();
  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m3_bus ();
  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_bus ();

  wb_arbiter_4x1 #(
    .WB_ADDR_WIDTH  (32),
    .WB_DATA_WIDTH  (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .m2  (m2_bus),
    .m3  (m3_bus),
    .s0  (s0_bus)
  );

  logic [3:0] ack_v, err_v;
  assign ack_v = {m3_bus.ack, m2_bus.ack, m1_bus.ack, m0_bus.ack};
  assign err_v = {m3_bus.err, m2_bus.err, m1_bus.err, m0_bus.err};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic c, input logic [31:0] a, input logic [2:0] t);
    case (i)
      0: begin m0_bus.cyc = c; m0_bus.stb = c; m0_bus.adr = a; m0_bus.cti = t; end
      1: begin m1_bus.cyc = c; m1_bus.stb = c; m1_bus.adr = a; m1_bus.cti = t; end
      2: begin m2_bus.cyc = c; m2_bus.stb = c; m2_bus.adr = a; m2_bus.cti = t; end
      default: begin m3_bus.cyc = c; m3_bus.stb = c; m3_bus.adr = a; m3_bus.cti = t; end
    endcase
  endtask

  initial begin
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'h0, 3'b000);
    m0_bus.dat_w = '0; m1_bus.dat_w = '0; m2_bus.dat_w = '0; m3_bus.dat_w = '0;
    m0_bus.sel = '0; m1_bus.sel = '0; m2_bus.sel = '0; m3_bus.sel = '0;
    m0_bus.we = 1'b0; m1_bus.we = 1'b0; m2_bus.we = 1'b0; m3_bus.we = 1'b0;
    m0_bus.bte = '0; m1_bus.bte = '0; m2_bus.bte = '0; m3_bus.bte = '0;
    s0_bus.ack = 1'b0; s0_bus.err = 1'b0; s0_bus.dat_r = '0;

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_cyc", 32'(s0_bus.cyc), 32'd0);
    check("rst_stb", 32'(s0_bus.stb), 32'd0);
    check("rst_ack", 32'(ack_v), 32'd0);
    check("rst_err", 32'(err_v), 32'd0);

    // Request pulse withdrawn before the grant edge is ignored
    drive(1, 1'b1, 32'h0000_0777, 3'b000);
    #3;
    drive(1, 1'b0, 32'h0, 3'b000);
    cycle();
    check("glitch_no_grant", 32'(s0_bus.cyc), 32'd0);
    cycle();
    check("glitch_still_idle", 32'(s0_bus.cyc), 32'd0);

    // Single master write, slave acks on the third BUSY cycle
    drive(2, 1'b1, 32'h0000_0100, 3'b000);
    m2_bus.we = 1'b1; m2_bus.dat_w = 32'hA5A5_0001; m2_bus.sel = 4'hF;
    #1;
    check("single_idle_cyc", 32'(s0_bus.cyc), 32'd0);
    cycle();
    check("single_cyc", 32'(s0_bus.cyc), 32'd1);
    check("single_adr", s0_bus.adr, 32'h0000_0100);
    check("single_datw", s0_bus.dat_w, 32'hA5A5_0001);
    check("single_we", 32'(s0_bus.we), 32'd1);
    check("single_sel", 32'(s0_bus.sel), 32'hF);
    cycle();
    check("single_wait_ack", 32'(ack_v), 32'd0);
    cycle();
    s0_bus.ack = 1'b1; s0_bus.dat_r = 32'hCAFE_0002;
    #1;
    check("single_ack", 32'(ack_v), 32'b0100);
    check("single_no_err", 32'(err_v), 32'd0);
    check("single_datr_m0", m0_bus.dat_r, 32'hCAFE_0002);
    cycle();
    s0_bus.ack = 1'b0;
    drive(2, 1'b0, 32'h0, 3'b000);
    m2_bus.we = 1'b0;
    #1;
    check("single_drop_cyc", 32'(s0_bus.cyc), 32'd0);
    cycle();
    check("single_idle_after", 32'(s0_bus.cyc), 32'd0);

    // Fairness from reset: all four request, expect 0,1,2,3,0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 32'h0000_1000 + 32'(i), 3'b000);
    for (int n = 0; n < 5; n++) begin
      int e;
      e = n % 4;
      cycle();
      check($sformatf("rr%0d_cyc", n), 32'(s0_bus.cyc), 32'd1);
      check($sformatf("rr%0d_adr", n), s0_bus.adr, 32'h0000_1000 + 32'(e));
      s0_bus.ack = 1'b1;
      #1;
      check($sformatf("rr%0d_ack", n), 32'(ack_v), 32'd1 << e);
      cycle();
      s0_bus.ack = 1'b0;
      drive(e, 1'b0, 32'h0, 3'b000);
      #1;
      check($sformatf("rr%0d_drop", n), 32'(s0_bus.cyc), 32'd0);
      cycle();
      check($sformatf("rr%0d_dead", n), 32'(s0_bus.cyc), 32'd0);
      if (n < 4) drive(e, 1'b1, 32'h0000_1000 + 32'(e), 3'b000);
    end
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'h0, 3'b000);

    // Burst hold: m1 4-beat incrementing burst with an STB gap, m0 waiting
    drive(0, 1'b1, 32'h0000_3000, 3'b000);
    drive(1, 1'b1, 32'h0000_0200, 3'b010);
    cycle();
    check("burst_grant", s0_bus.adr, 32'h0000_0200);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        m1_bus.stb = 1'b0;
        #1;
        check("burst_gap_stb", 32'(s0_bus.stb), 32'd0);
        check("burst_gap_cyc", 32'(s0_bus.cyc), 32'd1);
        check("burst_gap_adr", s0_bus.adr, 32'h0000_0204);
        cycle();
        m1_bus.stb = 1'b1;
      end
      m1_bus.adr = 32'h0000_0200 + 32'(4 * b);
      m1_bus.cti = (b == 3) ? 3'b111 : 3'b010;
      s0_bus.ack = 1'b1;
      #1;
      check($sformatf("burst%0d_adr", b), s0_bus.adr, 32'h0000_0200 + 32'(4 * b));
      check($sformatf("burst%0d_cti", b), 32'(s0_bus.cti), (b == 3) ? 32'd7 : 32'd2);
      check($sformatf("burst%0d_ack", b), 32'(ack_v), 32'b0010);
      cycle();
      s0_bus.ack = 1'b0;
    end
    drive(1, 1'b0, 32'h0, 3'b000);
    #1;
    check("burst_end_cyc", 32'(s0_bus.cyc), 32'd0);
    cycle();
    check("burst_dead", 32'(s0_bus.cyc), 32'd0);
    cycle();
    check("burst_m0_cyc", 32'(s0_bus.cyc), 32'd1);
    check("burst_m0_adr", s0_bus.adr, 32'h0000_3000);
    s0_bus.ack = 1'b1;
    #1;
    check("burst_m0_ack", 32'(ack_v), 32'b0001);
    cycle();
    s0_bus.ack = 1'b0;
    drive(0, 1'b0, 32'h0, 3'b000);
    cycle();

    // Timeout: m3 never answered, ERR after 8 STB cycles
    drive(3, 1'b1, 32'h0000_0400, 3'b000);
    cycle();
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("to_busy%0d_cyc", k), 32'(s0_bus.cyc), 32'd1);
      check($sformatf("to_busy%0d_err", k), 32'(err_v), 32'd0);
      cycle();
    end
    check("to_err_pulse", 32'(err_v), 32'b1000);
    check("to_terr_cyc", 32'(s0_bus.cyc), 32'd0);
    check("to_terr_stb", 32'(s0_bus.stb), 32'd0);
    check("to_terr_ack", 32'(ack_v), 32'd0);
    cycle();
    check("to_err_once", 32'(err_v), 32'd0);
    check("to_terr_hold", 32'(s0_bus.cyc), 32'd0);
    drive(0, 1'b1, 32'h0000_3000, 3'b000);
    cycle();
    check("to_m0_blocked", 32'(s0_bus.cyc), 32'd0);
    check("to_m0_no_err", 32'(err_v), 32'd0);
    drive(3, 1'b0, 32'h0, 3'b000);
    cycle();
    check("to_idle", 32'(s0_bus.cyc), 32'd0);
    cycle();
    check("to_m0_cyc", 32'(s0_bus.cyc), 32'd1);
    check("to_m0_adr", s0_bus.adr, 32'h0000_3000);
    s0_bus.ack = 1'b1;
    cycle();
    s0_bus.ack = 1'b0;
    drive(0, 1'b0, 32'h0, 3'b000);
    cycle();

    // ACK on the threshold cycle wins over the timeout
    drive(2, 1'b1, 32'h0000_0500, 3'b000);
    cycle();
    for (int k = 1; k < 8; k++) cycle();
    s0_bus.ack = 1'b1;
    #1;
    check("thr_ack", 32'(ack_v), 32'b0100);
    check("thr_no_err", 32'(err_v), 32'd0);
    cycle();
    s0_bus.ack = 1'b0;
    drive(2, 1'b0, 32'h0, 3'b000);
    #1;
    check("thr_after_err", 32'(err_v), 32'd0);
    cycle();
    check("thr_idle_err", 32'(err_v), 32'd0);

    // Reset during beat 2 of an m0 burst
    drive(0, 1'b1, 32'h0000_0600, 3'b010);
    drive(1, 1'b1, 32'h0000_0700, 3'b000);
    cycle();
    check("rb_grant_adr", s0_bus.adr, 32'h0000_0600);
    s0_bus.ack = 1'b1;
    #1;
    check("rb_beat1_ack", 32'(ack_v), 32'b0001);
    cycle();
    m0_bus.adr = 32'h0000_0604;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    s0_bus.ack = 1'b0;
    #1;
    check("rb_cyc", 32'(s0_bus.cyc), 32'd0);
    check("rb_ack", 32'(ack_v), 32'd0);
    check("rb_err", 32'(err_v), 32'd0);
    cycle();
    check("rb_regrant_cyc", 32'(s0_bus.cyc), 32'd1);
    check("rb_regrant_adr", s0_bus.adr, 32'h0000_0604);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
